// File: rtl/wb_rr_arbiter_wdt.sv
//------------------------------------------------------------------------------
// Module : wb_rr_arbiter_wdt
// Brief  : Round-robin whole-CYC arbiter for one shared Wishbone slave,
//          with a per-transfer stall watchdog that injects ERR and gates the slave.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_rr_arbiter_wdt #(
   parameter  int N_MASTERS      = 4,
   parameter  int TIMEOUT_CYCLES = 255,
   localparam int ID_W           = $clog2(N_MASTERS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_MASTERS-1:0] m_cyc,
   input  logic [N_MASTERS-1:0] m_stb,
   input  logic                 s_ack,
   input  logic                 s_err,
   output logic [N_MASTERS-1:0] gnt,
   output logic                 gnt_valid,
   output logic [ID_W-1:0]      gnt_id,
   output logic                 s_en,
   output logic                 m_err_inj,
   output logic [7:0]           tmo_count
);

   localparam int              WDT_W      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam bit              c_WDT_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [WDT_W-1:0] c_WDT_LAST = WDT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_OWN   = 2'd1,
      S_TMO   = 2'd2,
      S_ABORT = 2'd3
   } state_t;

   state_t               state_q;
   logic [N_MASTERS-1:0] gnt_q;
   logic [ID_W-1:0]      gnt_id_q;
   logic                 s_en_q;
   logic                 err_inj_q;
   logic [WDT_W-1:0]     wdt_q;
   logic [7:0]           tmo_count_q;

   logic                 w_found;
   logic [ID_W-1:0]      w_winner;
   logic [N_MASTERS-1:0] w_onehot;
   logic                 w_own_cyc;
   logic                 w_stall;
   logic                 w_tmo_hit;
   int                   w_idx;

   // gnt_id_q doubles as last_id: it always holds the most recent owner, so the
   // rotating scan starts just after it both in IDLE and at an OWN hand-over.
   always_comb begin
      w_found  = 1'b0;
      w_winner = gnt_id_q;
      w_idx    = 0;
      for (int k = 1; k <= N_MASTERS; k++) begin
         w_idx = int'(gnt_id_q) + k;
         if (w_idx >= N_MASTERS) begin
            w_idx = w_idx - N_MASTERS;
         end
         if (!w_found && m_cyc[w_idx[ID_W-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_idx[ID_W-1:0];
         end
      end
   end

   assign w_onehot  = N_MASTERS'(1) << w_winner;
   assign w_own_cyc = m_cyc[gnt_id_q];
   assign w_stall   = m_stb[gnt_id_q] & ~s_ack & ~s_err;
   assign w_tmo_hit = c_WDT_EN && w_stall && (wdt_q == c_WDT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         gnt_q       <= '0;
         gnt_id_q    <= ID_W'(N_MASTERS - 1);
         s_en_q      <= 1'b0;
         err_inj_q   <= 1'b0;
         wdt_q       <= '0;
         tmo_count_q <= '0;
      end else begin
         err_inj_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               wdt_q <= '0;
               if (w_found) begin
                  gnt_q    <= w_onehot;
                  gnt_id_q <= w_winner;
                  s_en_q   <= 1'b1;
                  state_q  <= S_OWN;
               end
            end
            S_OWN: begin
               // Release outranks a watchdog threshold reached in the same cycle.
               if (!w_own_cyc) begin
                  wdt_q <= '0;
                  if (w_found) begin
                     gnt_q    <= w_onehot;
                     gnt_id_q <= w_winner;
                     s_en_q   <= 1'b1;
                     state_q  <= S_OWN;
                  end else begin
                     gnt_q   <= '0;
                     s_en_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end
               end else if (w_tmo_hit) begin
                  wdt_q     <= '0;
                  s_en_q    <= 1'b0;
                  err_inj_q <= 1'b1;
                  state_q   <= S_TMO;
                  if (tmo_count_q != 8'hFF) begin
                     tmo_count_q <= tmo_count_q + 8'd1;
                  end
               end else if (c_WDT_EN && w_stall) begin
                  wdt_q <= wdt_q + 1'b1;
               end else begin
                  wdt_q <= '0;
               end
            end
            S_TMO: begin
               state_q <= S_ABORT;
            end
            S_ABORT: begin
               if (!w_own_cyc) begin
                  wdt_q <= '0;
                  if (w_found) begin
                     gnt_q    <= w_onehot;
                     gnt_id_q <= w_winner;
                     s_en_q   <= 1'b1;
                     state_q  <= S_OWN;
                  end else begin
                     gnt_q   <= '0;
                     s_en_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end
               end
            end
            default: begin
               gnt_q   <= '0;
               s_en_q  <= 1'b0;
               wdt_q   <= '0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = |gnt_q;
   assign gnt_id    = gnt_id_q;
   assign s_en      = s_en_q;
   assign m_err_inj = err_inj_q;
   assign tmo_count = tmo_count_q;

endmodule

`default_nettype wire
